dmem_arbiter: RTL and testbench

Single-port data-memory arbiter that shares the processor's data block RAM between the datapath load/store port (CPU) and a debug/loader port (DBG) used to preload operands and dump results without hierarchical peeking. Sits between the datapath and the data memory instance. It issues at most one access per cycle, stalls the loser, and tags the 1-cycle-latency read return to the correct requester. CPU has priority, and a starvation guard prevents DBG from being locked out.

---
 rtl/kgp_mem_pkg.sv | 19 +
 rtl/dmem_starve_ctr.sv | 58 +++++
 rtl/dmem_arbiter.sv | 104 ++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_mem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package kgp_mem_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int CNT_W          = 4;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic {
        NORMAL    = 1'b0,
        FORCE_DBG = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Starvation guard: counts conflicts the DBG port loses in a row and flags
// that DBG must win the next conflict once the limit is reached.
module dmem_starve_ctr
    import kgp_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic conflict,
    input  logic cpu_won,
    input  logic dbg_won,
    input  logic dbg_req,
    output logic force_dbg
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             dbg_lost;

    assign dbg_lost  = conflict & cpu_won;
    assign cnt_inc   = cnt + 1'b1;
    assign force_dbg = (state == FORCE_DBG);

    // NOTE: sequential state uses non-blocking assignments only, and every
    // flop here is cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            if (dbg_won || !dbg_req) begin
                cnt <= '0;
            end else if (dbg_lost && cnt != LIMIT) begin
                cnt <= cnt_inc;
            end

            case (state)
                NORMAL: begin
                    if (dbg_lost && cnt_inc == LIMIT) begin
                        state <= FORCE_DBG;
                    end
                end
                FORCE_DBG: begin
                    // Stay forced until DBG actually gets a slot.
                    if (dbg_won) begin
                        state <= NORMAL;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the CPU load/store port and the
// debug/loader port; CPU has priority, DBG is protected from starvation.
module dmem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   cpu_grant;
    logic   dbg_grant;
    logic   conflict;
    logic   force_dbg;
    logic   rd_pending;
    owner_e rd_owner;

    assign conflict = cpu_req & dbg_req;

    dmem_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .conflict  (conflict),
        .cpu_won   (cpu_grant),
        .dbg_won   (dbg_grant),
        .dbg_req   (dbg_req),
        .force_dbg (force_dbg)
    );

    // Grants are held off while reset is asserted so nothing reaches the RAM.
    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        cpu_grant = 1'b0;
        dbg_grant = 1'b0;
        if (rst) begin
            if (cpu_req && !(dbg_req && force_dbg)) begin
                cpu_grant = 1'b1;
            end else if (dbg_req) begin
                dbg_grant = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign dbg_gnt   = dbg_grant;

    always_comb begin
        mem_en    = cpu_grant | dbg_grant;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dbg_grant) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
        end
    end

    // Read latency is fixed at one cycle, so a single tag is enough.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_pending <= mem_en & ~mem_we;
            rd_owner   <= dbg_grant ? OWN_DBG : OWN_CPU;
        end
    end

    assign cpu_rvalid = rd_pending & (rd_owner == OWN_CPU);
    assign dbg_rvalid = rd_pending & (rd_owner == OWN_DBG);
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant checks plus a read-return
// scoreboard drained by an independent monitor.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t cpu_q[$];
    rd_exp_t dbg_q[$];
    int      cyc;
    int      n_pass;
    int      n_total;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model with registered read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        else n_pass++;
    endtask

    task automatic set_cpu(input logic req, input logic we, input int addr, input logic [31:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = ADDR_W'(addr); cpu_wdata = wd;
    endtask

    task automatic set_dbg(input logic req, input logic we, input int addr, input logic [31:0] wd);
        dbg_req = req; dbg_we = we; dbg_addr = ADDR_W'(addr); dbg_wdata = wd;
    endtask

    // One cycle: check grants and RAM drive at the negedge, queue any expected
    // read return, optionally assert reset before the next rising edge.
    task automatic tick(input logic exp_stall, input logic exp_gnt,
                        input logic [31:0] exp_rd, input bit rst_mid);
        logic cg, dg;
        @(negedge clk);
        cg = cpu_req & ~exp_stall;
        dg = exp_gnt;
        check("cpu_stall", cpu_stall, exp_stall);
        check("dbg_gnt",   dbg_gnt,   exp_gnt);
        check("mem_en",    mem_en,    cg | dg);
        if (cg | dg) begin
            check("mem_we",   mem_we,   dg ? dbg_we : cpu_we);
            check("mem_addr", mem_addr, dg ? dbg_addr : cpu_addr);
            if (mem_we) check("mem_wdata", mem_wdata, dg ? dbg_wdata : cpu_wdata);
        end else begin
            check("mem_we_idle", mem_we, 1'b0);
        end
        if (rst_mid) begin
            #1 rst = 1'b0;
            cpu_q.delete();
            dbg_q.delete();
        end else begin
            if (cg && !cpu_we) cpu_q.push_back('{due: cyc + 1, data: exp_rd});
            if (dg && !dbg_we) dbg_q.push_back('{due: cyc + 1, data: exp_rd});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read return must land on its due cycle with the right data.
    always @(negedge clk) begin
        check("rvalid_exclusive", cpu_rvalid & dbg_rvalid, 1'b0);
        if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
            check("cpu_rvalid", cpu_rvalid, 1'b1);
            check("cpu_rdata",  cpu_rdata,  cpu_q[0].data);
            void'(cpu_q.pop_front());
        end else begin
            check("cpu_rvalid_idle", cpu_rvalid, 1'b0);
        end
        if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
            check("dbg_rvalid", dbg_rvalid, 1'b1);
            check("dbg_rdata",  dbg_rdata,  dbg_q[0].data);
            void'(dbg_q.pop_front());
        end else begin
            check("dbg_rvalid_idle", dbg_rvalid, 1'b0);
        end
    end

    // Continuous conflict with limit 4: CPU, CPU, CPU, CPU, DBG.
    task automatic conflict_round(input logic [31:0] dbg_data);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) tick(1'b1, 1'b1, dbg_data, 1'b0);
            else        tick(1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        set_cpu(1'b1, 1'b1, 3, 32'h0000_0005);
        set_dbg(1'b0, 1'b0, 0, 32'h0);

        // Reset held with a CPU request pending: no access, CPU stalled.
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;

        // Released: CPU store 5 @3 granted the same cycle, then load it back.
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        set_cpu(1'b1, 1'b0, 3, 32'h0);
        tick(1'b0, 1'b0, 32'h0000_0005, 1'b0);
        set_cpu(1'b0, 1'b0, 0, 32'h0);

        // DBG only: ten writes, then ten back-to-back reads.
        for (int i = 0; i < 10; i++) begin
            set_dbg(1'b1, 1'b1, i, 32'h100 + i);
            tick(1'b0, 1'b1, 32'h0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            set_dbg(1'b1, 1'b0, i, 32'h0);
            tick(1'b0, 1'b1, 32'h100 + i, 1'b0);
        end

        // Preload 7 @0 and 9 @1, then alternate CPU and DBG loads.
        set_dbg(1'b1, 1'b1, 0, 32'd7);
        tick(1'b0, 1'b1, 32'h0, 1'b0);
        set_dbg(1'b1, 1'b1, 1, 32'd9);
        tick(1'b0, 1'b1, 32'h0, 1'b0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        set_cpu(1'b1, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b0, 32'd7, 1'b0);
        set_cpu(1'b0, 1'b0, 0, 32'h0);
        set_dbg(1'b1, 1'b0, 1, 32'h0);
        tick(1'b0, 1'b1, 32'd9, 1'b0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        // Continuous conflict: two full rounds of the 4:1 pattern.
        set_cpu(1'b1, 1'b1, 20, 32'hAA);
        set_dbg(1'b1, 1'b0, 1, 32'h0);
        conflict_round(32'd9);
        conflict_round(32'd9);
        set_cpu(1'b0, 1'b0, 0, 32'h0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        // Reach the forced-DBG state, reset, and expect CPU priority again.
        set_cpu(1'b1, 1'b1, 21, 32'hBB);
        set_dbg(1'b1, 1'b0, 1, 32'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        conflict_round(32'd9);
        set_cpu(1'b0, 1'b0, 0, 32'h0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset lands between a granted DBG load and its return.
        set_dbg(1'b1, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b1, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        // After that reset the guard starts from NORMAL with a zero count.
        set_cpu(1'b1, 1'b1, 22, 32'hCC);
        set_dbg(1'b1, 1'b0, 0, 32'h0);
        conflict_round(32'd7);
        set_cpu(1'b0, 1'b0, 0, 32'h0);
        set_dbg(1'b0, 1'b0, 0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b0);

        check("reads_outstanding", cpu_q.size() + dbg_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
